// File: rtl/bhtbtb_pkg.sv
// Shared types and helpers for the branch-history / branch-target table.
package bhtbtb_pkg;

  // 2-bit direction counter encodings
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam int FETCH_SLOTS = 16;  // 4B instructions per 64B fetch block
  localparam int BLK_OFF_W   = 6;   // byte offset bits within a fetch block
  localparam int MAX_TAG_W   = 32;  // storage width of the tag field; TAG_W <= this
  localparam int TGT_W       = 32;

  // One table entry; counters are packed so slot i sits at bits [2i+1:2i]
  typedef struct packed {
    logic                              valid;
    logic [MAX_TAG_W-1:0]              tag;
    logic [FETCH_SLOTS-1:0][1:0]       cnt;
    logic [TGT_W-1:0]                  target;
  } bhtbtb_entry_t;

  // Saturating 2-bit counter step
  function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
    else       return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bhtbtb_table_upd_fifo.sv
// Generic valid/ready FIFO buffering training requests. DEPTH must be a power of 2 (>= 2)
// so the pointers wrap naturally.
module bhtbtb_upd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push, pop;

  // Handshakes and pointer/occupancy next-state
  always_comb begin
    in_ready  = (cnt_q != (PTR_W+1)'(DEPTH));
    out_valid = (cnt_q != '0);
    out_data  = mem_q[rd_ptr_q];
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    cnt_d     = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write on push
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: rtl/bhtbtb_table.sv
// BHT/BTB storage: 1-cycle lookup per 64B fetch block, buffered 2-stage
// read-modify-write training. The table has a single read port shared by the lookup
// path and U1; a lookup wins, so U1 holds while lkp_valid is high.
module bhtbtb_table
  import bhtbtb_pkg::*;
#(
  parameter int IDX_W   = 6,
  parameter int TAG_W   = 20,
  parameter int UFIFO_D = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        lkp_valid,
  input  logic [63:0] lkp_pc,
  output logic        bhtbtb2dec_valid,
  output logic [63:0] bhtbtb2dec_pc,
  output logic [31:0] bht_rd_data,
  output logic [31:0] btb_rd_data,
  output logic        btbtag_hit,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [63:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_LSB = BLK_OFF_W + IDX_W;
  localparam int PC_HI   = TAG_LSB + TAG_W;      // first pc bit above the tag
  localparam int UPC_W   = PC_HI - 2;            // pc[PC_HI-1:2] kept per update
  localparam int UQ_W    = UPC_W + 1 + TGT_W;    // {pc bits, taken, target}

  bhtbtb_entry_t tbl_q [ENTRIES];

  // S1 lookup result
  logic        out_vld_q, out_vld_d, out_hit_q, out_hit_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic [31:0] out_bht_q, out_bht_d, out_btb_q, out_btb_d;

  // Update pipeline: upd_vld_q[0] = U1 occupied, upd_vld_q[1] = U2 occupied
  logic [1:0]      upd_vld_q, upd_vld_d;
  logic [UQ_W-1:0] u1_data_q, u1_data_d;
  logic            u2_we_q, u2_we_d;
  logic [IDX_W-1:0] u2_idx_q, u2_idx_d;
  bhtbtb_entry_t   u2_wdata_q, u2_wdata_d;

  logic            fifo_out_valid, fifo_out_ready;
  logic [UQ_W-1:0] fifo_out_data;

  logic [IDX_W-1:0] lkp_idx, u1_idx;
  logic [TAG_W-1:0] lkp_tag, u1_tag;
  logic [UPC_W-1:0] u1_upc;
  logic [3:0]       u1_slot;
  logic             u1_taken, u1_adv, u1_hit, lk_hit, fwd, we;
  logic [TGT_W-1:0] u1_tgt;
  bhtbtb_entry_t    lk_e, rd_e, wr_e;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{lkp_pc[BLK_OFF_W-1:0], upd_pc[1:0], upd_pc[63:PC_HI]};

  bhtbtb_upd_fifo #(.W(UQ_W), .DEPTH(UFIFO_D)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (upd_valid),
    .in_ready  (upd_ready),
    .in_data   ({upd_pc[PC_HI-1:2], upd_taken, upd_target}),
    .out_valid (fifo_out_valid),
    .out_ready (fifo_out_ready),
    .out_data  (fifo_out_data)
  );

  // S0 lookup: combinational table read, data held when no lookup is issued
  always_comb begin
    lkp_idx   = lkp_pc[TAG_LSB-1:BLK_OFF_W];
    lkp_tag   = lkp_pc[PC_HI-1:TAG_LSB];
    lk_e      = tbl_q[lkp_idx];
    lk_hit    = lk_e.valid && (lk_e.tag == MAX_TAG_W'(lkp_tag));
    out_vld_d = lkp_valid & ~flush;
    out_pc_d  = out_pc_q;
    out_hit_d = out_hit_q;
    out_bht_d = out_bht_q;
    out_btb_d = out_btb_q;
    if (lkp_valid) begin
      out_pc_d  = {lkp_pc[63:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
      out_hit_d = lk_hit;
      out_bht_d = lk_hit ? lk_e.cnt    : '0;
      out_btb_d = lk_hit ? lk_e.target : '0;
    end
  end

  // U1 read-modify-write with forwarding from U2 so back-to-back updates compose
  always_comb begin
    u1_upc   = u1_data_q[UQ_W-1 -: UPC_W];
    u1_taken = u1_data_q[TGT_W];
    u1_tgt   = u1_data_q[TGT_W-1:0];
    u1_slot  = u1_upc[3:0];
    u1_idx   = u1_upc[IDX_W+3:4];
    u1_tag   = u1_upc[UPC_W-1:IDX_W+4];

    u1_adv         = upd_vld_q[0] & ~lkp_valid;
    fifo_out_ready = ~upd_vld_q[0] | u1_adv;
    upd_vld_d[0]   = fifo_out_ready ? fifo_out_valid : upd_vld_q[0];
    upd_vld_d[1]   = u1_adv;
    u1_data_d      = (fifo_out_ready & fifo_out_valid) ? fifo_out_data : u1_data_q;

    fwd    = upd_vld_q[1] & u2_we_q & (u2_idx_q == u1_idx);
    rd_e   = fwd ? u2_wdata_q : tbl_q[u1_idx];
    u1_hit = rd_e.valid && (rd_e.tag == MAX_TAG_W'(u1_tag));
    wr_e   = rd_e;
    we     = 1'b0;
    if (u1_hit) begin
      we                = 1'b1;
      wr_e.cnt[u1_slot] = sat_cnt(rd_e.cnt[u1_slot], u1_taken);
      if (u1_taken) wr_e.target = u1_tgt;
    end else if (u1_taken) begin
      we                = 1'b1;
      wr_e.valid        = 1'b1;
      wr_e.tag          = MAX_TAG_W'(u1_tag);
      wr_e.cnt          = {FETCH_SLOTS{CNT_WNT}};
      wr_e.cnt[u1_slot] = CNT_WT;
      wr_e.target       = u1_tgt;
    end

    u2_we_d    = u2_we_q;
    u2_idx_d   = u2_idx_q;
    u2_wdata_d = u2_wdata_q;
    if (u1_adv) begin
      u2_we_d    = we;
      u2_idx_d   = u1_idx;
      u2_wdata_d = wr_e;
    end
  end

  // S1 result and update pipeline registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_vld_q  <= 1'b0;
      out_hit_q  <= 1'b0;
      out_pc_q   <= '0;
      out_bht_q  <= '0;
      out_btb_q  <= '0;
      upd_vld_q  <= '0;
      u1_data_q  <= '0;
      u2_we_q    <= 1'b0;
      u2_idx_q   <= '0;
      u2_wdata_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_hit_q  <= out_hit_d;
      out_pc_q   <= out_pc_d;
      out_bht_q  <= out_bht_d;
      out_btb_q  <= out_btb_d;
      upd_vld_q  <= upd_vld_d;
      u1_data_q  <= u1_data_d;
      u2_we_q    <= u2_we_d;
      u2_idx_q   <= u2_idx_d;
      u2_wdata_q <= u2_wdata_d;
    end
  end

  // U2 commit: visible to lookups from the next cycle on
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
    end else if (upd_vld_q[1] && u2_we_q) begin
      tbl_q[u2_idx_q] <= u2_wdata_q;
    end
  end

  assign bhtbtb2dec_valid = out_vld_q;
  assign bhtbtb2dec_pc    = out_pc_q;
  assign bht_rd_data      = out_bht_q;
  assign btb_rd_data      = out_btb_q;
  assign btbtag_hit       = out_hit_q;

endmodule

// File: tb/tb_bhtbtb_table.sv
// Scoreboard bench for bhtbtb_table: lookups push expected results, a negedge monitor
// pops and compares whenever the DUT presents a valid result.
module tb_bhtbtb_table;

  logic        clock = 1'b0, reset_n = 1'b0, flush = 1'b0, lkp_valid = 1'b0;
  logic [63:0] lkp_pc = '0, upd_pc = '0;
  logic        upd_valid = 1'b0, upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        bhtbtb2dec_valid, btbtag_hit, upd_ready;
  logic [63:0] bhtbtb2dec_pc;
  logic [31:0] bht_rd_data, btb_rd_data;

  typedef struct {
    logic [63:0] pc;
    logic        hit;
    logic [31:0] bht;
    logic [31:0] btb;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests_run = 0, tests_failed = 0;

  bhtbtb_table dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .lkp_valid(lkp_valid), .lkp_pc(lkp_pc),
    .bhtbtb2dec_valid(bhtbtb2dec_valid), .bhtbtb2dec_pc(bhtbtb2dec_pc),
    .bht_rd_data(bht_rd_data), .btb_rd_data(btb_rd_data), .btbtag_hit(btbtag_hit),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic lookup(input logic [63:0] pc, input logic hit,
                        input logic [31:0] bht, input logic [31:0] btb);
    lkp_valid = 1'b1;
    lkp_pc    = pc;
    sb.push_back('{pc: {pc[63:6], 6'd0}, hit: hit, bht: bht, btb: btb});
    tick();
    lkp_valid = 1'b0;
  endtask

  task automatic upd(input logic [63:0] pc, input logic taken, input logic [31:0] tgt);
    int n;
    n = 0;
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
    while (!upd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("upd_ready_timeout", 64'd0, 64'd1);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic drain();
    lkp_valid = 1'b0;
    repeat (6) tick();
  endtask

  // Result monitor
  always @(negedge clock) begin
    if (reset_n && bhtbtb2dec_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("pc",  bhtbtb2dec_pc, mon_e.pc);
        chk("hit", 64'(btbtag_hit), 64'(mon_e.hit));
        chk("bht", 64'(bht_rd_data), 64'(mon_e.bht));
        chk("btb", 64'(btb_rd_data), 64'(mon_e.btb));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    #1;
    chk("rst_valid", 64'(bhtbtb2dec_valid), 64'd0);
    chk("rst_hit",   64'(btbtag_hit), 64'd0);
    chk("rst_bht",   64'(bht_rd_data), 64'd0);
    chk("rst_btb",   64'(btb_rd_data), 64'd0);
    chk("rst_pc",    bhtbtb2dec_pc, 64'd0);
    chk("rst_ready", 64'(upd_ready), 64'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Cold lookup misses
    lookup(64'h8000_0040, 1'b0, 32'h0, 32'h0);

    // Allocation on taken miss; second pc in the same block reports the block base
    upd(64'h8000_0048, 1'b1, 32'h8000_1000);
    drain();
    lookup(64'h8000_0040, 1'b1, 32'h5555_5565, 32'h8000_1000);
    lookup(64'h8000_007c, 1'b1, 32'h5555_5565, 32'h8000_1000);

    // Back-to-back taken updates saturate at 11; target follows the last one
    upd(64'h8000_0048, 1'b1, 32'h8000_1100);
    upd(64'h8000_0048, 1'b1, 32'h8000_1200);
    upd(64'h8000_0048, 1'b1, 32'h8000_1300);
    drain();
    lookup(64'h8000_0040, 1'b1, 32'h5555_5575, 32'h8000_1300);
    for (int i = 0; i < 4; i++) upd(64'h8000_0048, 1'b0, 32'hdead_0000);
    drain();
    lookup(64'h8000_0040, 1'b1, 32'h5555_5545, 32'h8000_1300);
    upd(64'h8000_0048, 1'b0, 32'hdead_0001);
    drain();
    lookup(64'h8000_0040, 1'b1, 32'h5555_5545, 32'h8000_1300);

    // Commit-cycle lookup sees old data, the next one sees new data
    upd(64'h8000_0048, 1'b1, 32'h8000_1400);
    tick(); tick();
    lookup(64'h8000_0040, 1'b1, 32'h5555_5545, 32'h8000_1300);
    lookup(64'h8000_0040, 1'b1, 32'h5555_5555, 32'h8000_1400);
    drain();

    // Flushed lookup produces no result; the following one returns normally
    lkp_valid = 1'b1; flush = 1'b1; lkp_pc = 64'h8000_0040;
    tick();
    flush = 1'b0;
    sb.push_back('{pc: 64'h8000_0040, hit: 1'b1, bht: 32'h5555_5555, btb: 32'h8000_1400});
    @(negedge clock);
    chk("flush_valid", 64'(bhtbtb2dec_valid), 64'd0);
    @(posedge clock); #1;
    lkp_valid = 1'b0;
    tick();

    // Same idx, different tag: miss, and a not-taken update leaves A intact
    lookup(64'h8000_1040, 1'b0, 32'h0, 32'h0);
    upd(64'h8000_1048, 1'b0, 32'hdead_0002);
    drain();
    lookup(64'h8000_1040, 1'b0, 32'h0, 32'h0);
    lookup(64'h8000_0040, 1'b1, 32'h5555_5555, 32'h8000_1400);
    drain();

    // Continuous lookups hold U1 so the FIFO fills; held request must not be lost
    lkp_valid = 1'b1; lkp_pc = 64'h0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{pc: 64'h0, hit: 1'b0, bht: 32'h0, btb: 32'h0});
      upd_valid = 1'b1; upd_pc = 64'h9000_0088;
      upd_taken = (i == 0);
      upd_target = 32'h9000_0100 * (i + 1);
      tick();
    end
    upd_taken = 1'b1; upd_target = 32'h9000_0400;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{pc: 64'h0, hit: 1'b0, bht: 32'h0, btb: 32'h0});
      chk("full_ready", 64'(upd_ready), 64'd0);
      tick();
    end
    lkp_valid = 1'b0;
    chk("full_ready_pop_cycle", 64'(upd_ready), 64'd0);
    tick();
    chk("ready_after_pop", 64'(upd_ready), 64'd1);
    tick();
    upd_valid = 1'b0;
    drain();
    lookup(64'h9000_0080, 1'b1, 32'h5555_5555, 32'h9000_0400);
    drain();

    // Reset mid-operation clears the S1 result and the table
    lkp_valid = 1'b1; lkp_pc = 64'h8000_0040;
    upd_valid = 1'b1; upd_pc = 64'h8000_0048; upd_taken = 1'b1; upd_target = 32'h1234_5678;
    tick();
    lkp_valid = 1'b0; upd_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bhtbtb2dec_valid), 64'd0);
    chk("midrst_bht",   64'(bht_rd_data), 64'd0);
    chk("midrst_ready", 64'(upd_ready), 64'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    drain();
    lookup(64'h8000_0040, 1'b0, 32'h0, 32'h0);
    drain();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
